// File: rtl/ahb_gpio_ports.sv
// Multi-port AHB-Lite GPIO slave: direction, atomic set/clear/toggle outputs,
// synchronised inputs with sticky rising-edge interrupt flags and a two-cycle ERROR response.
module ahb_gpio_ports #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned PORT_WIDTH  = 16,
    parameter logic [31:0] START_ADDR  = 32'h0000_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                            HCLK,
    input  logic                            HRESET,
    input  logic [31:0]                     haddr,
    input  logic [31:0]                     hwdata,
    input  logic                            hwrite,
    input  logic                            hsel,
    input  logic [1:0]                      htrans,
    input  logic [2:0]                      hsize,
    output logic [31:0]                     hrdata,
    output logic                            hready,
    output logic                            hresp,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_in,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] gpio_oe,
    output logic                            irq
);

    localparam int unsigned PIW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned GW   = NUM_PORTS * PORT_WIDTH;
    localparam logic [31:0] SPAN = 32'(NUM_PORTS * 32);

    localparam logic [2:0] REG_IN   = 3'd0;
    localparam logic [2:0] REG_OUT  = 3'd1;
    localparam logic [2:0] REG_DIR  = 3'd2;
    localparam logic [2:0] REG_SET  = 3'd3;
    localparam logic [2:0] REG_CLR  = 3'd4;
    localparam logic [2:0] REG_TGL  = 3'd5;
    localparam logic [2:0] REG_IEN  = 3'd6;
    localparam logic [2:0] REG_STAT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    state_t state_q, state_next_c;

    // Address-phase decode
    logic [31:0]    rel_addr_c;
    logic [PIW-1:0] port_c;
    logic [2:0]     reg_c;
    logic           accept_c;
    logic           err_c;

    assign rel_addr_c = haddr - START_ADDR;
    assign reg_c      = rel_addr_c[4:2];
    assign accept_c   = hsel & htrans[1] & hready;
    assign err_c      = (rel_addr_c >= SPAN) | (hsize != 3'b010) | (haddr[1:0] != 2'b00)
                      | (hwrite & (reg_c == REG_IN));

    generate
        if (NUM_PORTS > 1) begin : g_port_field
            assign port_c = rel_addr_c[5 +: PIW];
        end else begin : g_single_port
            assign port_c = '0;
        end
    endgenerate

    // Data-phase control captured at the end of the address phase
    logic           dp_valid;
    logic           dp_write;
    logic           dp_err;
    logic [PIW-1:0] dp_port;
    logic [2:0]     dp_reg;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_err   <= 1'b0;
            dp_port  <= '0;
            dp_reg   <= '0;
        end else begin
            dp_valid <= accept_c;
            if (accept_c) begin
                dp_write <= hwrite;
                dp_err   <= err_c;
                dp_port  <= port_c;
                dp_reg   <= reg_c;
            end
        end
    end

    logic                  commit_c;
    logic                  rd_c;
    logic [PORT_WIDTH-1:0] wdata_c;
    logic [NUM_PORTS-1:0]  port_hit_c;
    logic                  unused_c;

    assign commit_c = dp_valid & dp_write & ~dp_err;
    assign rd_c     = dp_valid & ~dp_write & ~dp_err;
    assign wdata_c  = hwdata[PORT_WIDTH-1:0];
    assign unused_c = ^{hwdata, 1'b0};

    always_comb begin
        port_hit_c = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_hit_c[p] = commit_c && (dp_port == PIW'(p));
        end
    end

    // Input synchroniser and edge detector over the whole pin bus
    logic [SYNC_STAGES-1:0][GW-1:0] sync_q;
    logic [GW-1:0]                  prev_q;
    logic [GW-1:0]                  sync_in_c;
    logic [GW-1:0]                  rise_c;

    assign sync_in_c = sync_q[SYNC_STAGES-1];
    assign rise_c    = sync_in_c & ~prev_q;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            prev_q <= sync_in_c;
        end
    end

    // Per-port registers
    logic [PORT_WIDTH-1:0] out_q  [NUM_PORTS];
    logic [PORT_WIDTH-1:0] dir_q  [NUM_PORTS];
    logic [PORT_WIDTH-1:0] ien_q  [NUM_PORTS];
    logic [PORT_WIDTH-1:0] stat_q [NUM_PORTS];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                out_q[p]  <= '0;
                dir_q[p]  <= '0;
                ien_q[p]  <= '0;
                stat_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (port_hit_c[p]) begin
                    case (dp_reg)
                        REG_OUT: out_q[p] <= wdata_c;
                        REG_SET: out_q[p] <= out_q[p] | wdata_c;
                        REG_CLR: out_q[p] <= out_q[p] & ~wdata_c;
                        REG_TGL: out_q[p] <= out_q[p] ^ wdata_c;
                        REG_DIR: dir_q[p] <= wdata_c;
                        REG_IEN: ien_q[p] <= wdata_c;
                        default: ;
                    endcase
                end
                // A new edge overrides a simultaneous write-1-to-clear
                stat_q[p] <= (stat_q[p] & ~((port_hit_c[p] && (dp_reg == REG_STAT)) ? wdata_c : '0))
                           | rise_c[p*PORT_WIDTH +: PORT_WIDTH];
            end
        end
    end

    logic irq_any_c;

    always_comb begin
        irq_any_c = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            irq_any_c = irq_any_c | (|(stat_q[p] & ien_q[p]));
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_any_c;
        end
    end

    logic [PORT_WIDTH-1:0] in_c [NUM_PORTS];

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_pins
            assign gpio_out[g*PORT_WIDTH +: PORT_WIDTH] = out_q[g];
            assign gpio_oe[g*PORT_WIDTH +: PORT_WIDTH]  = dir_q[g];
            assign in_c[g] = sync_in_c[g*PORT_WIDTH +: PORT_WIDTH];
        end
    endgenerate

    // Read mux; zero outside a legal read data phase
    always_comb begin
        hrdata = 32'h0;
        if (rd_c) begin
            case (dp_reg)
                REG_IN:   hrdata = 32'(in_c[dp_port]);
                REG_OUT:  hrdata = 32'(out_q[dp_port]);
                REG_DIR:  hrdata = 32'(dir_q[dp_port]);
                REG_IEN:  hrdata = 32'(ien_q[dp_port]);
                REG_STAT: hrdata = 32'(stat_q[dp_port]);
                default:  hrdata = 32'h0;
            endcase
        end
    end

    // Response state machine
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next_c;
        end
    end

    always_comb begin
        state_next_c = state_q;
        case (state_q)
            ST_IDLE: if (accept_c && err_c) state_next_c = ST_ERR1;
            ST_ERR1: state_next_c = ST_ERR2;
            ST_ERR2: state_next_c = (accept_c && err_c) ? ST_ERR1 : ST_IDLE;
            default: state_next_c = ST_IDLE;
        endcase
    end

    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        case (state_q)
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            ST_ERR2: begin
                hready = 1'b1;
                hresp  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_gpio_ports.sv
// Directed bench for ahb_gpio_ports: register access, atomic output ops, error responses,
// edge capture / interrupt timing and reset behaviour.
module tb_ahb_gpio_ports;

    localparam int unsigned NP = 4;
    localparam int unsigned PW = 16;
    localparam logic [31:0] B  = 32'h4000_0000;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic [31:0]      haddr;
    logic [31:0]      hwdata;
    logic             hwrite;
    logic             hsel;
    logic [1:0]       htrans;
    logic [2:0]       hsize;
    logic [31:0]      hrdata;
    logic             hready;
    logic             hresp;
    logic [NP*PW-1:0] gpio_in;
    logic [NP*PW-1:0] gpio_out;
    logic [NP*PW-1:0] gpio_oe;
    logic             irq;

    int n_vec = 0;
    int n_err = 0;

    ahb_gpio_ports #(
        .NUM_PORTS  (NP),
        .PORT_WIDTH (PW),
        .START_ADDR (B),
        .SYNC_STAGES(2)
    ) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .haddr   (haddr),
        .hwdata  (hwdata),
        .hwrite  (hwrite),
        .hsel    (hsel),
        .htrans  (htrans),
        .hsize   (hsize),
        .hrdata  (hrdata),
        .hready  (hready),
        .hresp   (hresp),
        .gpio_in (gpio_in),
        .gpio_out(gpio_out),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [31:0] ra(input int p, input int r);
        return B + 32'(p * 32 + r * 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Drive one address phase; returns just after the accepting edge with the bus idle
    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        @(posedge HCLK);
        #1;
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_phase(a, 1'b1, 3'b010);
        hwdata = d;
        @(posedge HCLK);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr_phase(a, 1'b0, 3'b010);
        @(negedge HCLK);
        check(tag, hrdata, exp);
        @(posedge HCLK);
        #1;
    endtask

    // Write immediately followed by a read of the same register
    task automatic wr_rd(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hwrite = 1'b1;
        hsize  = 3'b010;
        @(posedge HCLK);
        #1;
        hwdata = d;
        hwrite = 1'b0;
        @(posedge HCLK);
        #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        @(negedge HCLK);
        check(tag, hrdata, exp);
        @(posedge HCLK);
        #1;
    endtask

    task automatic err_chk(input string tag, input logic [31:0] a, input logic w,
                           input logic [2:0] sz);
        addr_phase(a, w, sz);
        hwdata = 32'hFFFF_FFFF;
        @(negedge HCLK);
        check({tag, "_err1"}, 32'({hready, hresp}), 32'h1);
        check({tag, "_rdata"}, hrdata, 32'h0);
        @(negedge HCLK);
        check({tag, "_err2"}, 32'({hready, hresp}), 32'h3);
        @(posedge HCLK);
        #1;
        check({tag, "_idle"}, 32'({hready, hresp}), 32'h2);
    endtask

    initial begin
        HRESET  = 1'b1;
        haddr   = 32'h0;
        hwdata  = 32'h0;
        hwrite  = 1'b0;
        hsel    = 1'b0;
        htrans  = 2'b00;
        hsize   = 3'b010;
        gpio_in = '0;
        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;

        check("rst_hready", 32'(hready), 32'h1);
        check("rst_hresp", 32'(hresp), 32'h0);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_gpio_out", gpio_out[31:0], 32'h0);
        check("rst_gpio_oe", gpio_oe[31:0], 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rd_chk("rst_out0", ra(0, 1), 32'h0);
        rd_chk("rst_dir0", ra(0, 2), 32'h0);
        rd_chk("rst_stat0", ra(0, 7), 32'h0);

        // Atomic output operations on port 1
        wr(ra(1, 1), 32'h0000_00F0);
        wr(ra(1, 3), 32'h0000_0003);
        wr(ra(1, 4), 32'h0000_0010);
        wr(ra(1, 5), 32'h0000_0101);
        check("p1_gpio_out", 32'(gpio_out[16 +: 16]), 32'h01E2);
        check("p0_gpio_out", 32'(gpio_out[0 +: 16]), 32'h0);
        rd_chk("p1_out", ra(1, 1), 32'h01E2);
        rd_chk("p1_set_rd", ra(1, 3), 32'h0);

        // Direction register masking
        wr(ra(1, 2), 32'hFFFF_FFFF);
        rd_chk("p1_dir", ra(1, 2), 32'h0000_FFFF);
        check("p1_gpio_oe", gpio_oe[31:0], 32'hFFFF_0000);

        // Synchronised input readback
        gpio_in[16 +: 16] = 16'h5A5A;
        repeat (3) @(posedge HCLK);
        #1;
        rd_chk("p1_in", ra(1, 0), 32'h0000_5A5A);
        gpio_in = '0;
        repeat (4) @(posedge HCLK);
        #1;

        // Error responses, none of which may touch a register
        err_chk("wr_in", ra(1, 0), 1'b1, 3'b010);
        err_chk("oor", B + 32'h80, 1'b1, 3'b010);
        err_chk("byte", ra(1, 1), 1'b1, 3'b000);
        err_chk("misal", B + 32'h05, 1'b1, 3'b010);
        err_chk("below", B - 32'h4, 1'b1, 3'b010);
        err_chk("rd_half", ra(1, 1), 1'b0, 3'b001);
        check("err_p1_out", 32'(gpio_out[16 +: 16]), 32'h01E2);
        check("err_p0_out", 32'(gpio_out[0 +: 16]), 32'h0);
        rd_chk("err_p1_out_rd", ra(1, 1), 32'h01E2);
        rd_chk("err_p3_stat", ra(3, 7), 32'h0);

        // Back-to-back write then read
        wr_rd("b2b_ien0", ra(0, 6), 32'h0000_A5A5, 32'h0000_A5A5);
        wr(ra(0, 6), 32'h0);

        // Edge capture and interrupt timing on port 2 bit 3
        wr(ra(2, 6), 32'h8);
        gpio_in[35] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge HCLK);
            #1;
            check($sformatf("irq_lat%0d", i), 32'(irq), (i == 4) ? 32'h1 : 32'h0);
        end
        rd_chk("p2_stat", ra(2, 7), 32'h8);
        wr(ra(2, 7), 32'h8);
        check("irq_w1c_hold", 32'(irq), 32'h1);
        @(posedge HCLK);
        #1;
        check("irq_w1c_clr", 32'(irq), 32'h0);

        // Capture without enable raises no interrupt
        gpio_in[48] = 1'b1;
        repeat (5) @(posedge HCLK);
        #1;
        check("irq_unen", 32'(irq), 32'h0);
        rd_chk("p3_stat", ra(3, 7), 32'h1);
        wr(ra(3, 7), 32'h1);
        rd_chk("p3_stat_clr", ra(3, 7), 32'h0);

        // Edge arriving in the same cycle as the W1C commit wins
        gpio_in[35] = 1'b0;
        repeat (4) @(posedge HCLK);
        #1;
        gpio_in[35] = 1'b1;
        @(posedge HCLK);
        #1;
        wr(ra(2, 7), 32'h8);
        rd_chk("collide_stat", ra(2, 7), 32'h8);
        check("collide_irq", 32'(irq), 32'h1);
        wr(ra(2, 7), 32'h8);
        rd_chk("collide_clr", ra(2, 7), 32'h0);
        check("collide_irq_clr", 32'(irq), 32'h0);

        // Reset in a write data phase
        gpio_in = '0;
        repeat (4) @(posedge HCLK);
        #1;
        addr_phase(ra(1, 1), 1'b1, 3'b010);
        hwdata = 32'h0000_1234;
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        check("rstwr_gpio_out", 32'(gpio_out[16 +: 16]), 32'h0);
        check("rstwr_resp", 32'({hready, hresp}), 32'h2);
        rd_chk("rstwr_out", ra(1, 1), 32'h0);

        // Reset while the error response is in flight
        addr_phase(ra(0, 0), 1'b1, 3'b010);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        check("rsterr_resp", 32'({hready, hresp}), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
